// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped data cache: address split,
// default geometry and controller state encoding.
package dcache_pkg;

   localparam int ADDR_BITS     = 32;
   localparam int WORD_BITS     = 32;
   localparam int OFFSET_BITS   = 5;
   localparam int DEF_NUM_LINES = 16;
   localparam int DEF_LINE_BITS = 256;

   typedef enum logic [2:0] {
      IDLE,
      MISS,
      WRITEBACK,
      READ,
      REFILL
   } state_t;

   function automatic int tag_bits(input int num_lines);
      return ADDR_BITS - OFFSET_BITS - $clog2(num_lines);
   endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: one combinational read port, one write port.
// Only valid and dirty are reset; tags and data keep their contents.
module dcache_sram
   import dcache_pkg::*;
#(
   parameter int NUM_LINES = DEF_NUM_LINES,
   parameter int LINE_BITS = DEF_LINE_BITS,
   parameter int TAG_BITS  = tag_bits(DEF_NUM_LINES)
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [$clog2(NUM_LINES)-1:0] rd_index,
   output logic [TAG_BITS-1:0]          rd_tag,
   output logic                         rd_valid,
   output logic                         rd_dirty,
   output logic [LINE_BITS-1:0]         rd_data,
   input  logic                         wr_en,
   input  logic [$clog2(NUM_LINES)-1:0] wr_index,
   input  logic [TAG_BITS-1:0]          wr_tag,
   input  logic                         wr_dirty,
   input  logic [LINE_BITS-1:0]         wr_data
);

   logic [NUM_LINES-1:0] valid;
   logic [NUM_LINES-1:0] dirty;
   logic [TAG_BITS-1:0]  tags  [NUM_LINES];
   logic [LINE_BITS-1:0] lines [NUM_LINES];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid <= '0;
         dirty <= '0;
      end else if (wr_en) begin
         valid[wr_index] <= 1'b1;
         dirty[wr_index] <= wr_dirty;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         tags[wr_index]  <= wr_tag;
         lines[wr_index] <= wr_data;
      end
   end

   assign rd_tag   = tags[rd_index];
   assign rd_valid = valid[rd_index];
   assign rd_dirty = dirty[rd_index];
   assign rd_data  = lines[rd_index];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache controller: combinational hit path,
// blocking miss handling with optional dirty write-back before the fill.
module dcache_controller
   import dcache_pkg::*;
#(
   parameter int NUM_LINES = DEF_NUM_LINES,
   parameter int LINE_BITS = DEF_LINE_BITS
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cpu_req_i,
   input  logic                 cpu_write_i,
   input  logic [31:0]          cpu_addr_i,
   input  logic [31:0]          cpu_data_i,
   output logic [31:0]          cpu_data_o,
   output logic                 cpu_stall_o,
   output logic                 mem_enable_o,
   output logic                 mem_write_o,
   output logic [31:0]          mem_addr_o,
   output logic [LINE_BITS-1:0] mem_data_o,
   input  logic [LINE_BITS-1:0] mem_data_i,
   input  logic                 mem_ack_i
);

   localparam int INDEX_BITS = $clog2(NUM_LINES);
   localparam int TAG_BITS   = tag_bits(NUM_LINES);
   localparam int SEL_BITS   = $clog2(LINE_BITS / WORD_BITS);

   state_t                state, state_nxt;
   logic [INDEX_BITS-1:0] index;
   logic [TAG_BITS-1:0]   tag, rd_tag, wr_tag;
   logic [SEL_BITS-1:0]   sel;
   logic                  rd_valid, rd_dirty, wr_en, wr_dirty, hit;
   logic [LINE_BITS-1:0]  rd_data, wr_data;

   // The stalled pipeline holds the address, so it is used live throughout a miss.
   assign index = cpu_addr_i[OFFSET_BITS +: INDEX_BITS];
   assign tag   = cpu_addr_i[ADDR_BITS-1 -: TAG_BITS];
   assign sel   = cpu_addr_i[2 +: SEL_BITS];
   assign hit   = cpu_req_i && (state == IDLE) && rd_valid && (rd_tag == tag);

   dcache_sram #(
      .NUM_LINES (NUM_LINES),
      .LINE_BITS (LINE_BITS),
      .TAG_BITS  (TAG_BITS)
   ) u_sram (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .rd_index (index),
      .rd_tag   (rd_tag),
      .rd_valid (rd_valid),
      .rd_dirty (rd_dirty),
      .rd_data  (rd_data),
      .wr_en    (wr_en),
      .wr_index (index),
      .wr_tag   (wr_tag),
      .wr_dirty (wr_dirty),
      .wr_data  (wr_data)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      wr_en        = 1'b0;
      wr_tag       = tag;
      wr_dirty     = 1'b0;
      wr_data      = rd_data;
      cpu_stall_o  = 1'b0;
      cpu_data_o   = '0;
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = {tag, index, {OFFSET_BITS{1'b0}}};
      mem_data_o   = rd_data;
      case (state)
         IDLE: begin
            if (hit) begin
               if (cpu_write_i) begin
                  wr_en    = 1'b1;
                  wr_dirty = 1'b1;
                  wr_data[sel*WORD_BITS +: WORD_BITS] = cpu_data_i;
               end else begin
                  cpu_data_o = rd_data[sel*WORD_BITS +: WORD_BITS];
               end
            end else if (cpu_req_i) begin
               cpu_stall_o = 1'b1;
               state_nxt   = MISS;
            end
         end
         MISS: begin
            cpu_stall_o = 1'b1;
            state_nxt   = (rd_valid && rd_dirty) ? WRITEBACK : READ;
         end
         WRITEBACK: begin
            cpu_stall_o  = 1'b1;
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = {rd_tag, index, {OFFSET_BITS{1'b0}}};
            if (mem_ack_i) state_nxt = READ;
         end
         READ: begin
            cpu_stall_o  = 1'b1;
            mem_enable_o = 1'b1;
            if (mem_ack_i) begin
               wr_en     = 1'b1;
               wr_data   = mem_data_i;
               state_nxt = REFILL;
            end
         end
         REFILL: begin
            cpu_stall_o = 1'b1;
            state_nxt   = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Reset must silence the CPU-facing outputs even while a request is held.
      if (rst_i) begin
         cpu_stall_o = 1'b0;
         cpu_data_o  = '0;
         wr_en       = 1'b0;
      end
   end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench: flat memory model, software-view expected data and a
// tag/valid/dirty reference model predicting misses, write-backs and stalls.
module tb_dcache_controller;
   import dcache_pkg::*;

   localparam int LB = 256;

   logic          clk_i = 0, rst_i = 0;
   logic          cpu_req_i, cpu_write_i;
   logic [31:0]   cpu_addr_i, cpu_data_i, cpu_data_o;
   logic          cpu_stall_o, mem_enable_o, mem_write_o, mem_ack_i;
   logic [31:0]   mem_addr_o;
   logic [LB-1:0] mem_data_o, mem_data_i;

   always #5 clk_i = ~clk_i;

   dcache_controller #(.NUM_LINES(16), .LINE_BITS(LB)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .cpu_req_i    (cpu_req_i),
      .cpu_write_i  (cpu_write_i),
      .cpu_addr_i   (cpu_addr_i),
      .cpu_data_i   (cpu_data_i),
      .cpu_data_o   (cpu_data_o),
      .cpu_stall_o  (cpu_stall_o),
      .mem_enable_o (mem_enable_o),
      .mem_write_o  (mem_write_o),
      .mem_addr_o   (mem_addr_o),
      .mem_data_o   (mem_data_o),
      .mem_data_i   (mem_data_i),
      .mem_ack_i    (mem_ack_i)
   );

   int errors = 0, checks = 0;
   int ack_delay = 10;

   typedef struct {
      bit          w;
      bit [31:0]   addr;
      bit [LB-1:0] data;
   } txn_t;

   bit [31:0] mem_store [bit [31:0]];
   bit [31:0] exp_mem   [bit [31:0]];
   bit [22:0] mtag   [16];
   bit        mvalid [16];
   bit        mdirty [16];
   txn_t      log_q [$];

   function automatic bit [31:0] init_word(input bit [31:0] a);
      return ({a[31:2], 2'b00} * 32'h9E3779B1) ^ 32'h1234_5678;
   endfunction

   function automatic bit [31:0] mem_word(input bit [31:0] a);
      bit [31:0] wa = {a[31:2], 2'b00};
      return mem_store.exists(wa) ? mem_store[wa] : init_word(wa);
   endfunction

   function automatic bit [31:0] exp_word(input bit [31:0] a);
      bit [31:0] wa = {a[31:2], 2'b00};
      return exp_mem.exists(wa) ? exp_mem[wa] : mem_word(wa);
   endfunction

   function automatic bit [LB-1:0] mem_line(input bit [31:0] la);
      bit [LB-1:0] l;
      for (int k = 0; k < 8; k++) l[k*32 +: 32] = mem_word(la + 32'(4*k));
      return l;
   endfunction

   // Memory: ack ack_delay cycles after enable is seen, one-cycle pulse.
   int            cnt;
   logic          resp_ack = 0;
   logic [LB-1:0] resp_data = '0;
   assign mem_ack_i  = resp_ack;
   assign mem_data_i = resp_data;

   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt <= 0; resp_ack <= 0;
      end else if (!mem_enable_o || resp_ack) begin
         cnt <= 0; resp_ack <= 0;
      end else if (cnt >= ack_delay - 1) begin
         resp_ack  <= 1;
         resp_data <= mem_line(mem_addr_o);
      end else begin
         cnt <= cnt + 1;
      end
   end

   always @(posedge clk_i) begin
      if (!rst_i && resp_ack) begin
         txn_t t;
         t.w    = mem_write_o;
         t.addr = mem_addr_o;
         t.data = mem_write_o ? mem_data_o : mem_data_i;
         log_q.push_back(t);
         if (mem_write_o)
            for (int k = 0; k < 8; k++) mem_store[mem_addr_o + 32'(4*k)] = mem_data_o[k*32 +: 32];
      end
   end

   task automatic mdl_reset();
      for (int i = 0; i < 16; i++) begin mvalid[i] = 0; mdirty[i] = 0; end
      exp_mem.delete();
   endtask

   task automatic mdl(input bit w, input bit [31:0] a, input bit [31:0] d,
                      output bit miss, output bit wb, output bit [31:0] wb_addr);
      int idx;
      idx     = int'(a[8:5]);
      miss    = !(mvalid[idx] && mtag[idx] == a[31:9]);
      wb      = miss && mvalid[idx] && mdirty[idx];
      wb_addr = {mtag[idx], a[8:5], 5'b0};
      if (miss) begin mtag[idx] = a[31:9]; mvalid[idx] = 1; mdirty[idx] = 0; end
      if (w) begin mdirty[idx] = 1; exp_mem[{a[31:2], 2'b00}] = d; end
   endtask

   // Hold the request until stall drops; returns stalled cycles and load data.
   task automatic access(input bit w, input bit [31:0] a, input bit [31:0] d,
                         output int stalls, output bit [31:0] rdata);
      cpu_req_i = 1; cpu_write_i = w; cpu_addr_i = a; cpu_data_i = d;
      stalls = 0;
      #1;
      while (cpu_stall_o && stalls <= 300) begin
         stalls++;
         @(posedge clk_i); #1;
      end
      rdata = cpu_data_o;
      @(posedge clk_i); #1;
      cpu_req_i = 0;
   endtask

   task automatic test_reset();
      cpu_req_i = 1; cpu_write_i = 0; cpu_addr_i = 32'h100;
      #2 rst_i = 1;
      #1;
      checks++; if (cpu_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", cpu_stall_o); end
      checks++; if (cpu_data_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", cpu_data_o); end
      checks++; if (mem_enable_o !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b want 0", mem_enable_o); end
      checks++; if (mem_write_o !== 1'b0) begin errors++; $display("FAIL reset_write: got %b want 0", mem_write_o); end
      cpu_req_i = 0;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 0;
      mdl_reset();
      @(posedge clk_i); #1;
   endtask

   task automatic test_first_load();
      int st; bit [31:0] rd; bit m, wb; bit [31:0] wa;
      ack_delay = 10;
      log_q.delete();
      mdl(0, 32'h40, 0, m, wb, wa);
      access(0, 32'h40, 0, st, rd);
      checks++; if (st != 14) begin errors++; $display("FAIL first_load_stalls: got %0d want 14", st); end
      checks++; if (log_q.size() != 1 || log_q[0].w || log_q[0].addr != 32'h40) begin
         errors++; $display("FAIL first_load_txn: got n=%0d want one READ at 00000040", log_q.size()); end
      checks++; if (rd !== init_word(32'h40)) begin errors++; $display("FAIL first_load_data: got %h want %h", rd, init_word(32'h40)); end
   endtask

   task automatic test_store_hit();
      int st; bit [31:0] rd; bit m, wb; bit [31:0] wa;
      log_q.delete();
      mdl(1, 32'h44, 32'hDEADBEEF, m, wb, wa);
      access(1, 32'h44, 32'hDEADBEEF, st, rd);
      checks++; if (st != 0) begin errors++; $display("FAIL store_hit_stalls: got %0d want 0", st); end
      access(0, 32'h44, 0, st, rd);
      checks++; if (st != 0 || rd !== 32'hDEADBEEF) begin
         errors++; $display("FAIL store_hit_load: got %h stalls=%0d want deadbeef stalls=0", rd, st); end
      checks++; if (dut.u_sram.dirty[2] !== 1'b1) begin errors++; $display("FAIL store_hit_dirty: got %b want 1", dut.u_sram.dirty[2]); end
      checks++; if (log_q.size() != 0) begin errors++; $display("FAIL store_hit_mem: got %0d txns want 0", log_q.size()); end
   endtask

   task automatic test_dirty_conflict();
      int st; bit [31:0] rd; bit m, wb; bit [31:0] wa;
      log_q.delete();
      mdl(0, 32'h240, 0, m, wb, wa);
      access(0, 32'h240, 0, st, rd);
      checks++; if (st != 25) begin errors++; $display("FAIL dirty_stalls: got %0d want 25", st); end
      checks++; if (log_q.size() != 2 || !log_q[0].w || log_q[0].addr != 32'h40 || log_q[0].data[63:32] != 32'hDEADBEEF) begin
         errors++; $display("FAIL dirty_writeback: got n=%0d want WB to 00000040 with deadbeef at word 1", log_q.size()); end
      checks++; if (log_q.size() != 2 || log_q[1].w || log_q[1].addr != 32'h240) begin
         errors++; $display("FAIL dirty_read: got n=%0d want READ at 00000240", log_q.size()); end
      checks++; if (rd !== init_word(32'h240)) begin errors++; $display("FAIL dirty_data: got %h want %h", rd, init_word(32'h240)); end
   endtask

   task automatic test_clean_conflict();
      int st; bit [31:0] rd; bit m, wb; bit [31:0] wa;
      log_q.delete();
      mdl(0, 32'h44, 0, m, wb, wa);
      access(0, 32'h44, 0, st, rd);
      checks++; if (st != 14) begin errors++; $display("FAIL clean_stalls: got %0d want 14", st); end
      checks++; if (log_q.size() != 1 || log_q[0].w || log_q[0].addr != 32'h40) begin
         errors++; $display("FAIL clean_txn: got n=%0d want single READ at 00000040", log_q.size()); end
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL clean_data: got %h want deadbeef", rd); end
   endtask

   task automatic test_reset_mid_read();
      int n; int st; bit [31:0] rd; bit m, wb; bit [31:0] wa;
      cpu_req_i = 1; cpu_write_i = 0; cpu_addr_i = 32'h80;
      n = 0;
      while (!(mem_enable_o && !mem_write_o) && n < 100) begin @(posedge clk_i); #1; n++; end
      checks++; if (n >= 100) begin errors++; $display("FAIL midread_reach: got timeout want READ"); end
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1;
      #1;
      checks++; if (mem_enable_o !== 1'b0 || cpu_stall_o !== 1'b0) begin
         errors++; $display("FAIL midread_reset: got enable=%b stall=%b want 0 0", mem_enable_o, cpu_stall_o); end
      cpu_req_i = 0;
      @(posedge clk_i); #1 rst_i = 0;
      mdl_reset();
      @(posedge clk_i); #1;
      log_q.delete();
      mdl(0, 32'h80, 0, m, wb, wa);
      access(0, 32'h80, 0, st, rd);
      checks++; if (st != 14 || rd !== init_word(32'h80)) begin
         errors++; $display("FAIL midread_reload: got stalls=%0d data=%h want 14 %h", st, rd, init_word(32'h80)); end
   endtask

   task automatic test_req_drop();
      int n; int st; bit [31:0] rd; bit m, wb; bit [31:0] wa;
      log_q.delete();
      mdl(0, 32'hC0, 0, m, wb, wa);
      cpu_req_i = 1; cpu_write_i = 0; cpu_addr_i = 32'hC0;
      n = 0;
      while (!(mem_enable_o && !mem_write_o) && n < 100) begin @(posedge clk_i); #1; n++; end
      cpu_req_i = 0;
      while (cpu_stall_o && n < 200) begin @(posedge clk_i); #1; n++; end
      checks++; if (n >= 200 || log_q.size() != 1) begin
         errors++; $display("FAIL drop_complete: got n=%0d txns=%0d want fill done", n, log_q.size()); end
      access(0, 32'hC0, 0, st, rd);
      checks++; if (st != 0 || rd !== init_word(32'hC0)) begin
         errors++; $display("FAIL drop_hit: got stalls=%0d data=%h want 0 %h", st, rd, init_word(32'hC0)); end
   endtask

   task automatic test_random();
      int st, exp_st; bit [31:0] rd, a, d, ew; bit w, m, wb; bit [31:0] wa; bit [LB-1:0] el;
      for (int i = 0; i < 80; i++) begin
         ack_delay = $urandom_range(1, 4);
         a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 15) << 5) | ($urandom_range(0, 7) << 2);
         w = 1'($urandom_range(0, 1));
         d = $urandom;
         log_q.delete();
         mdl(w, a, d, m, wb, wa);
         for (int k = 0; k < 8; k++) el[k*32 +: 32] = exp_word(wa + 32'(4*k));
         ew = exp_word(a);
         exp_st = !m ? 0 : (wb ? 2*ack_delay + 5 : ack_delay + 4);
         access(w, a, d, st, rd);
         checks++; if (st != exp_st) begin errors++; $display("FAIL rnd_stalls[%0d]: got %0d want %0d", i, st, exp_st); end
         checks++; if (log_q.size() != (m ? (wb ? 2 : 1) : 0)) begin
            errors++; $display("FAIL rnd_txns[%0d]: got %0d want miss=%0d wb=%0d", i, log_q.size(), m, wb); end
         else if (m) begin
            checks++; if (log_q[log_q.size()-1].w || log_q[log_q.size()-1].addr != {a[31:5], 5'b0}) begin
               errors++; $display("FAIL rnd_read[%0d]: got %h want READ %h", i, log_q[log_q.size()-1].addr, {a[31:5], 5'b0}); end
            if (wb) begin
               checks++; if (!log_q[0].w || log_q[0].addr != wa || log_q[0].data != el) begin
                  errors++; $display("FAIL rnd_wb[%0d]: got addr %h want %h with model line", i, log_q[0].addr, wa); end
            end
         end
         if (!w) begin
            checks++; if (rd !== ew) begin errors++; $display("FAIL rnd_load[%0d]: got %h want %h", i, rd, ew); end
         end
      end
   endtask

   initial begin
      cpu_req_i = 0; cpu_write_i = 0; cpu_addr_i = 0; cpu_data_i = 0;
      test_reset();
      test_first_load();
      test_store_hit();
      test_dirty_conflict();
      test_clean_conflict();
      test_reset_mid_read();
      test_req_drop();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 SHALL have parameter NUM_LINES, default 16, number of direct-mapped cache lines (power of two).
REQ-002 SHALL have parameter LINE_BITS, default 256, cache line / memory bus width.
REQ-003 SHALL have clk_i  input  1  sole clock, rising edge.
REQ-004 SHALL have rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have cpu_req_i  input  1  MEM-stage access valid (load or store).
REQ-006 SHALL have cpu_write_i  input  1  1 = store, 0 = load.
REQ-007 SHALL have cpu_addr_i  input  32  byte address (bits [1:0] ignored).
REQ-008 SHALL have cpu_data_i  input  32  store data.
REQ-009 SHALL have cpu_data_o  output  32  load data.
REQ-010 SHALL have cpu_stall_o  output  1  freezes PC and all pipeline registers when high.
REQ-011 SHALL have mem_enable_o  output  1  memory request valid.
REQ-012 SHALL have mem_write_o  output  1  1 = line write-back, 0 = line fill.
REQ-013 SHALL have mem_addr_o  output  32  line-aligned memory address.
REQ-014 SHALL have mem_data_o  output  LINE_BITS  write-back line.
REQ-015 SHALL have mem_data_i  input  LINE_BITS  fill line.
REQ-016 SHALL have mem_ack_i  input  1  one-cycle completion pulse from memory.

Function
REQ-017 Address split SHALL be offset [4:0], index [log2(NUM_LINES)+4:5], tag = remaining upper bits (23 bits at default).
REQ-018 Hit SHALL be combinational: cpu_req_i && valid[index] && tag match, state IDLE.
REQ-019 Read hit SHALL drive cpu_data_o with word offset[4:2] in the same cycle, cpu_stall_o = 0.
REQ-020 Write hit SHALL update that word and set dirty[index] at the next clock edge, cpu_stall_o = 0.
REQ-021 Miss in IDLE SHALL assert cpu_stall_o combinationally in the same cycle and move to MISS next edge.
REQ-022 cpu_stall_o SHALL stay high in MISS, WRITEBACK, READ, REFILL; low only in IDLE on hit or with cpu_req_i = 0.
REQ-023 MISS SHALL go to WRITEBACK if valid && dirty for the victim, else to READ.
REQ-024 WRITEBACK SHALL drive mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {victim tag, index, 5'b0}, mem_data_o = victim line; on mem_ack_i go to READ.
REQ-025 READ SHALL drive mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {req tag, index, 5'b0}; on mem_ack_i write mem_data_i into the line, set tag, valid = 1, dirty = 0, go to REFILL.
REQ-026 REFILL SHALL last one cycle then return to IDLE, where the replayed access hits per REQ-019/020.
REQ-027 mem_enable_o SHALL be held constant until mem_ack_i and SHALL be low in IDLE, MISS, REFILL (WRITEBACK to READ therefore keeps it high with mem_write_o falling).
REQ-028 mem_ack_i outside WRITEBACK/READ SHALL be ignored.
REQ-029 cpu_req_i falling mid-miss SHALL not abort; the fill completes and FSM returns to IDLE.
REQ-030 cpu_addr_i/cpu_write_i SHALL be held stable by the stalled pipeline; the controller SHALL not latch them.
REQ-031 With cpu_req_i = 0, cpu_data_o SHALL be 0 and no state or array change SHALL occur.

Reset
REQ-032 rst_i high SHALL immediately force state IDLE, all valid and dirty bits 0, mem_enable_o = 0, mem_write_o = 0, cpu_stall_o = 0, cpu_data_o = 0.
REQ-033 Reset mid-WRITEBACK/READ SHALL abandon the memory transaction; the data and tag arrays SHALL not be reset.

Structure
REQ-034 State encoding (IDLE, MISS, WRITEBACK, READ, REFILL), line/tag/index widths SHALL live in shared package dcache_pkg.
REQ-035 Tag/valid/dirty/data storage SHALL be sub-module dcache_sram, one read port, one write port; FSM and hit logic in dcache_controller.

Verification
REQ-036 Load 0x00000040 after reset -> stall same cycle, READ at mem_addr 0x00000040, ack after 10 cycles, stall drops in IDLE, cpu_data_o = word 0 of fill.
REQ-037 Store 0xDEADBEEF to 0x00000044 (line resident) -> no stall, later load 0x00000044 returns 0xDEADBEEF, dirty[2] = 1.
REQ-038 Load 0x00000240 (same index 2, dirty) -> WRITEBACK to 0x00000040 carrying 0xDEADBEEF at word 1, then READ 0x00000240, stall throughout.
REQ-039 Clean-conflict load -> no WRITEBACK, mem_write_o never high, single READ.
REQ-040 rst_i pulsed in READ before ack -> mem_enable_o low immediately, subsequent load of same address misses again.
REQ-041 cpu_req_i dropped in READ, ack delivered -> line valid, FSM IDLE, next request to it hits with zero stall.
